mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 54 +++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory with a fixed-latency, fully pipelined read path.
// The storage array is never reset; the pipeline is cleared asynchronously.
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int WORD_AW = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy
);
    localparam int DEPTH = 1 << WORD_AW;

    logic [15:0]        mem_q [DEPTH];
    logic [WORD_AW-1:0] idx;
    logic               rd_req;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [15:0]        dat_q [LATENCY];
    logic [15:0]        dat_d [LATENCY];

    assign idx    = addr[WORD_AW:1];
    assign rd_req = enable && !wr;

    // rst_n gates the write so requests held during reset never commit
    always_ff @(posedge clk)
        if (rst_n && enable && wr) mem_q[idx] <= data_in;

    always_comb begin
        vld_d[0] = rd_req;
        dat_d[0] = rd_req ? mem_q[idx] : '0;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end

    assign data_valid = vld_q[LATENCY-1];
    assign data_out   = data_valid ? dat_q[LATENCY-1] : '0;
    assign busy       = |vld_q;
endmodule
